// File: rtl/itype_scheduler.sv
// Commit-side scheduler: compacts up to NRET retiring instructions per cycle into a
// circular FIFO and presents them one per cycle to the single-lane itype detector.
package mure_pkg;
   typedef enum logic [7:0] {
      ADD    = 8'd0,
      SUB    = 8'd1,
      LD     = 8'd2,
      SD     = 8'd3,
      JAL    = 8'd4,
      JALR   = 8'd5,
      BRANCH = 8'd6,
      CSR    = 8'd7
   } fu_op;
endpackage

module itype_scheduler #(
   parameter int NRET  = 2,
   parameter int DEPTH = 8,
   parameter int XLEN  = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [NRET-1:0]            valid_i,
   input  mure_pkg::fu_op [NRET-1:0]  op_i,
   input  logic [NRET-1:0]            branch_taken_i,
   input  logic [NRET-1:0][XLEN-1:0]  pc_i,
   input  logic                       exception_i,
   input  logic                       interrupt_i,
   output logic                       ready_o,
   output logic                       det_valid_o,
   input  logic                       det_ready_i,
   output mure_pkg::fu_op             det_op_o,
   output logic                       det_branch_taken_o,
   output logic                       det_exception_o,
   output logic                       det_interrupt_o,
   output logic [XLEN-1:0]            det_pc_o,
   output logic                       overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int KW = $clog2(NRET + 2);

   typedef struct packed {
      mure_pkg::fu_op    op;
      logic              branch_taken;
      logic              exception;
      logic              interrupt;
      logic [XLEN-1:0]   pc;
   } entry_t;

   entry_t          mem_r [DEPTH];
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            overflow_r;

   entry_t          push_ent_s [NRET+1];
   logic [KW-1:0]   push_cnt_s;
   logic [AW-1:0]   wr_idx_s [NRET+1];
   logic            full_s;
   logic            ready_s;
   logic            push_s;
   logic            drop_s;
   logic            pop_s;
   entry_t          head_s;
   entry_t          det_s;

   // Compact valid ports into slots 0..k-1; a trap without a port-0 commit gets its own slot first.
   always_comb begin
      entry_t ent_v;
      for (int i = 0; i <= NRET; i++) begin
         push_ent_s[i] = '0;
      end
      push_cnt_s = '0;
      ent_v      = '0;
      if (!valid_i[0] && (exception_i || interrupt_i)) begin
         ent_v.exception = exception_i;
         ent_v.interrupt = interrupt_i;
         ent_v.pc        = pc_i[0];
         push_ent_s[0]   = ent_v;
         push_cnt_s      = KW'(1'b1);
      end else begin
         push_cnt_s = '0;
      end
      for (int p = 0; p < NRET; p++) begin
         if (valid_i[p]) begin
            ent_v.op           = op_i[p];
            ent_v.branch_taken = branch_taken_i[p];
            ent_v.exception    = (p == 0) ? exception_i : 1'b0;
            ent_v.interrupt    = (p == 0) ? interrupt_i : 1'b0;
            ent_v.pc           = pc_i[p];
            push_ent_s[push_cnt_s] = ent_v;
            push_cnt_s         = push_cnt_s + KW'(1'b1);
         end else begin
            push_cnt_s = push_cnt_s;
         end
      end
   end

   // Storage slot for each compacted push position, wrapping mod DEPTH.
   always_comb begin
      for (int i = 0; i <= NRET; i++) begin
         wr_idx_s[i] = AW'(wr_ptr_r[AW-1:0] + AW'(i));
      end
   end

   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   // Threshold covers the worst case of NRET commits plus a standalone trap entry.
   assign ready_s = !full_s && ((CW'(DEPTH) - count_r) >= CW'(NRET + 1));
   assign push_s  = (push_cnt_s != '0) && ready_s && !flush_i;
   assign drop_s  = (push_cnt_s != '0) && !ready_s && !flush_i;
   assign pop_s   = (count_r != '0) && det_ready_i && !flush_i;

   // Pointers, occupancy and sticky overflow; flush outranks any same-cycle push or pop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else if (flush_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= push_s ? (wr_ptr_r + (AW+1)'(push_cnt_s)) : wr_ptr_r;
         rd_ptr_r   <= pop_s ? (rd_ptr_r + (AW+1)'(1'b1)) : rd_ptr_r;
         count_r    <= count_r + (push_s ? CW'(push_cnt_s) : CW'(1'b0))
                                - (pop_s ? CW'(1'b1) : CW'(1'b0));
         overflow_r <= overflow_r | drop_s;
      end
   end

   // Entry storage: a dropped cycle writes nothing at all.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i <= NRET; i++) begin
         if (push_s && (KW'(i) < push_cnt_s)) begin
            mem_r[wr_idx_s[i]] <= push_ent_s[i];
         end
      end
   end

   assign head_s = mem_r[rd_ptr_r[AW-1:0]];

   // Head presentation, forced to zero while empty.
   always_comb begin
      det_s       = '0;
      det_valid_o = (count_r != '0);
      if (det_valid_o) begin
         det_s = head_s;
      end else begin
         det_s = '0;
      end
   end

   assign det_op_o           = det_s.op;
   assign det_branch_taken_o = det_s.branch_taken;
   assign det_exception_o    = det_s.exception;
   assign det_interrupt_o    = det_s.interrupt;
   assign det_pc_o           = det_s.pc;
   assign ready_o            = ready_s;
   assign overflow_o         = overflow_r;

endmodule

// File: tb/tb_itype_scheduler.sv
// Scoreboard bench for itype_scheduler: expected entries are queued as commits are
// driven and compared against the head whenever the DUT presents one.
module tb_itype_scheduler;
   import mure_pkg::*;

   localparam int NRET  = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 64;

   typedef struct packed {
      logic [7:0]  op;
      logic        tk;
      logic        ex;
      logic        ir;
      logic [63:0] pc;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       flush;
   logic [NRET-1:0]            valid;
   fu_op [NRET-1:0]            op;
   logic [NRET-1:0]            taken;
   logic [NRET-1:0][XLEN-1:0]  pc;
   logic                       exc;
   logic                       irq;
   logic                       ready;
   logic                       det_valid;
   logic                       det_ready;
   fu_op                       det_op;
   logic                       det_tk;
   logic                       det_ex;
   logic                       det_ir;
   logic [XLEN-1:0]            det_pc;
   logic                       ovf;

   exp_t q[$];
   logic m_ovf;
   int   n_tests;
   int   n_fail;

   always #5 clk = ~clk;

   itype_scheduler #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
      .valid_i            (valid),
      .op_i               (op),
      .branch_taken_i     (taken),
      .pc_i               (pc),
      .exception_i        (exc),
      .interrupt_i        (irq),
      .ready_o            (ready),
      .det_valid_o        (det_valid),
      .det_ready_i        (det_ready),
      .det_op_o           (det_op),
      .det_branch_taken_o (det_tk),
      .det_exception_o    (det_ex),
      .det_interrupt_o    (det_ir),
      .det_pc_o           (det_pc),
      .overflow_o         (ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic clr();
      valid = '0;
      exc   = 1'b0;
      irq   = 1'b0;
      flush = 1'b0;
      taken = '0;
      op[0] = ADD;
      op[1] = ADD;
      pc    = '0;
   endtask

   // Check current outputs against the model, then advance the model by one edge.
   task automatic tick();
      exp_t e[$];
      exp_t t;
      bit   mready;
      @(negedge clk);
      mready = (DEPTH - q.size()) >= (NRET + 1);
      check("det_valid", 64'(det_valid), 64'(q.size() != 0));
      check("ready", 64'(ready), 64'(mready));
      check("overflow", 64'(ovf), 64'(m_ovf));
      check("count", 64'(dut.count_r), 64'(q.size()));
      if (q.size() != 0) begin
         check("head_op", 64'(det_op), 64'(q[0].op));
         check("head_taken", 64'(det_tk), 64'(q[0].tk));
         check("head_exc", 64'(det_ex), 64'(q[0].ex));
         check("head_irq", 64'(det_ir), 64'(q[0].ir));
         check("head_pc", det_pc, q[0].pc);
      end else begin
         check("empty_op", 64'(det_op), 64'd0);
         check("empty_pc", det_pc, 64'd0);
      end
      if (!valid[0] && (exc || irq)) begin
         t = '0;
         t.ex = exc;
         t.ir = irq;
         t.pc = pc[0];
         e.push_back(t);
      end
      for (int p = 0; p < NRET; p++) begin
         if (valid[p]) begin
            t    = '0;
            t.op = 8'(op[p]);
            t.tk = taken[p];
            t.ex = (p == 0) ? exc : 1'b0;
            t.ir = (p == 0) ? irq : 1'b0;
            t.pc = pc[p];
            e.push_back(t);
         end
      end
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if ((q.size() != 0) && det_ready) void'(q.pop_front());
         if (e.size() != 0) begin
            if (mready) begin
               foreach (e[i]) q.push_back(e[i]);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      m_ovf     = 1'b0;
      clr();
      det_ready = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset then idle
      tick();
      tick();

      // dual commit, branch first then jalr
      valid = 2'b11; op[0] = BRANCH; op[1] = JALR; taken = 2'b01;
      pc[0] = 64'h1000; pc[1] = 64'h1004; det_ready = 1'b1;
      tick();
      clr();
      repeat (3) tick();

      // interrupt alone
      det_ready = 1'b0;
      irq = 1'b1; pc[0] = 64'h8000_0000;
      tick();
      clr();
      tick();
      det_ready = 1'b1;
      repeat (2) tick();

      // backpressure: 3 accepted dual commits, 4th dropped
      det_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid = 2'b11; op[0] = LD; op[1] = SD; taken = 2'b10;
         pc[0] = 64'h3000 + 64'(16 * i); pc[1] = 64'h3004 + 64'(16 * i);
         tick();
      end
      clr();
      det_ready = 1'b1;
      repeat (8) tick();

      // wrap: sustained single commit
      for (int i = 0; i < 20; i++) begin
         valid = 2'b01; op[0] = ADD; pc[0] = 64'h2000 + 64'(4 * i);
         tick();
      end
      clr();
      repeat (2) tick();

      // flush with count=5 and a same-cycle push
      det_ready = 1'b0;
      valid = 2'b11; pc[0] = 64'h4000; pc[1] = 64'h4004; tick();
      valid = 2'b11; pc[0] = 64'h4008; pc[1] = 64'h400c; tick();
      valid = 2'b01; pc[0] = 64'h4010; tick();
      valid = 2'b11; pc[0] = 64'h4014; pc[1] = 64'h4018; flush = 1'b1;
      tick();
      clr();
      tick();

      // asynchronous reset mid-stream
      valid = 2'b11; pc[0] = 64'h5000; pc[1] = 64'h5004; tick();
      valid = 2'b11; pc[0] = 64'h5008; pc[1] = 64'h500c; tick();
      clr();
      #2;
      rst = 1'b1;
      #1;
      check("rst_det_valid", 64'(det_valid), 64'd0);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_overflow", 64'(ovf), 64'd0);
      check("rst_pc", det_pc, 64'd0);
      q.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // random traffic
      for (int i = 0; i < 80; i++) begin
         valid     = 2'($urandom_range(0, 3));
         taken     = 2'($urandom_range(0, 3));
         op[0]     = fu_op'($urandom_range(0, 7));
         op[1]     = fu_op'($urandom_range(0, 7));
         pc[0]     = {$urandom, $urandom};
         pc[1]     = {$urandom, $urandom};
         exc       = ($urandom_range(0, 7) == 0);
         irq       = ($urandom_range(0, 7) == 0);
         det_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         tick();
      end
      clr();
      det_ready = 1'b1;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
